// File: rtl/shift_arbiter.sv
// Round-robin front end for one shared combinational barrel shifter.
// Two request channels, operand latch toward the shifter, and a registered result with a valid/ready handshake.
module shift_arbiter #(
    parameter int WIDTH = 8,
    parameter int SHW   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req0_din,
    input  logic [SHW-1:0]   req0_shamt,
    input  logic             req0_l_or_r,
    input  logic             req0_a_or_l,
    input  logic [WIDTH-1:0] req1_din,
    input  logic [SHW-1:0]   req1_shamt,
    input  logic             req1_l_or_r,
    input  logic             req1_a_or_l,
    output logic [WIDTH-1:0] sh_din,
    output logic [SHW-1:0]   sh_shamt,
    output logic             sh_l_or_r,
    output logic             sh_a_or_l,
    input  logic [WIDTH-1:0] sh_dout,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_data,
    output logic             res_id,
    input  logic             res_ready,
    output logic [7:0]       ops_done
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t           state_q;
    logic             last_grant_q;
    logic [WIDTH-1:0] sh_din_q;
    logic [SHW-1:0]   sh_shamt_q;
    logic             sh_l_or_r_q;
    logic             sh_a_or_l_q;
    logic             res_valid_q;
    logic [WIDTH-1:0] res_data_q;
    logic             res_id_q;
    logic [7:0]       ops_done_q;

    logic grant;
    logic accept;

    // A lone requester wins outright; on a tie the channel not served last wins.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned and infers a latch.
        grant     = req_valid[1];
        req_ready = '0;
        if (req_valid == 2'b11) begin
            grant = ~last_grant_q;
        end
        if (state_q == IDLE && req_valid != 2'b00) begin
            req_ready[grant] = 1'b1;
        end
    end

    assign accept = (req_ready != 2'b00);

    always_ff @(posedge clk) begin
        // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            sh_din_q     <= '0;
            sh_shamt_q   <= '0;
            sh_l_or_r_q  <= 1'b0;
            sh_a_or_l_q  <= 1'b0;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            res_id_q     <= 1'b0;
            ops_done_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (grant) begin
                            sh_din_q    <= req1_din;
                            sh_shamt_q  <= req1_shamt;
                            sh_l_or_r_q <= req1_l_or_r;
                            sh_a_or_l_q <= req1_a_or_l;
                        end else begin
                            sh_din_q    <= req0_din;
                            sh_shamt_q  <= req0_shamt;
                            sh_l_or_r_q <= req0_l_or_r;
                            sh_a_or_l_q <= req0_a_or_l;
                        end
                        res_id_q     <= grant;
                        last_grant_q <= grant;
                        state_q      <= EXEC;
                    end
                end
                EXEC: begin
                    // The shifter has had a full cycle to settle on the latched operands.
                    res_data_q  <= sh_dout;
                    res_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        ops_done_q  <= ops_done_q + 8'd1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sh_din    = sh_din_q;
    assign sh_shamt  = sh_shamt_q;
    assign sh_l_or_r = sh_l_or_r_q;
    assign sh_a_or_l = sh_a_or_l_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;
    assign ops_done  = ops_done_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter with a behavioural barrel shifter on the sh_* port.
// Expected results go into a scoreboard queue at issue time and are popped when res_valid rises.
module tb_shift_arbiter;

    typedef struct packed {
        logic [7:0] data;
        logic       id;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [7:0] req0_din, req1_din;
    logic [2:0] req0_shamt, req1_shamt;
    logic       req0_l_or_r, req0_a_or_l, req1_l_or_r, req1_a_or_l;
    logic [7:0] sh_din, sh_dout;
    logic [2:0] sh_shamt;
    logic       sh_l_or_r, sh_a_or_l;
    logic       res_valid;
    logic [7:0] res_data;
    logic       res_id;
    logic       res_ready;
    logic [7:0] ops_done;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];
    int   exp_ops;
    logic exp_grant;

    always #5 clk = ~clk;

    shift_arbiter #(.WIDTH(8), .SHW(3)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req0_din(req0_din), .req0_shamt(req0_shamt),
        .req0_l_or_r(req0_l_or_r), .req0_a_or_l(req0_a_or_l),
        .req1_din(req1_din), .req1_shamt(req1_shamt),
        .req1_l_or_r(req1_l_or_r), .req1_a_or_l(req1_a_or_l),
        .sh_din(sh_din), .sh_shamt(sh_shamt),
        .sh_l_or_r(sh_l_or_r), .sh_a_or_l(sh_a_or_l),
        .sh_dout(sh_dout),
        .res_valid(res_valid), .res_data(res_data), .res_id(res_id),
        .res_ready(res_ready), .ops_done(ops_done)
    );

    function automatic logic [7:0] shf(input logic [7:0] d, input logic [2:0] s,
                                       input logic lr, input logic al);
        logic [7:0] r;
        if (lr)      r = d << s;
        else if (al) r = 8'($signed(d) >>> s);
        else         r = d >> s;
        return r;
    endfunction

    assign sh_dout = shf(sh_din, sh_shamt, sh_l_or_r, sh_a_or_l);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called mid-cycle in IDLE; returns one cycle after the accept edge.
    task automatic issue(input logic ch, input logic [7:0] d, input logic [2:0] s,
                         input logic lr, input logic al, input logic [7:0] exp);
        int waited = 0;
        if (ch) begin
            req1_din = d; req1_shamt = s; req1_l_or_r = lr; req1_a_or_l = al;
        end else begin
            req0_din = d; req0_shamt = s; req0_l_or_r = lr; req0_a_or_l = al;
        end
        req_valid[ch] = 1'b1;
        #1;
        while (req_ready[ch] !== 1'b1 && waited < 20) begin
            @(posedge clk); #2;
            waited++;
        end
        check("issue_ready", {30'd0, req_ready}, ch ? 32'd2 : 32'd1);
        sb.push_back('{data: exp, id: ch});
        @(posedge clk); #1;
        req_valid[ch] = 1'b0;
    endtask

    // Called one cycle after the accept edge (EXEC); holds res_ready low for 'hold' DONE cycles.
    task automatic collect(input int hold);
        exp_t e;
        res_ready = (hold == 0);
        check("lat_exec_valid", {31'd0, res_valid}, 32'd0);
        @(posedge clk); #1;
        check("lat_done_valid", {31'd0, res_valid}, 32'd1);
        if (sb.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
            e = '0;
        end else begin
            e = sb.pop_front();
        end
        check("res_data", {24'd0, res_data}, {24'd0, e.data});
        check("res_id", {31'd0, res_id}, {31'd0, e.id});
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check("bp_valid", {31'd0, res_valid}, 32'd1);
            check("bp_data", {24'd0, res_data}, {24'd0, e.data});
            check("bp_id", {31'd0, res_id}, {31'd0, e.id});
            check("bp_req_ready", {30'd0, req_ready}, 32'd0);
            check("bp_ops", {24'd0, ops_done}, exp_ops);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        exp_ops++;
        check("consume_valid", {31'd0, res_valid}, 32'd0);
        check("consume_ops", {24'd0, ops_done}, exp_ops);
    endtask

    // Both channels held valid; grants must alternate starting from exp_grant.
    task automatic contend(input int n);
        exp_t e;
        logic g;
        res_ready = 1'b1;
        for (int k = 0; k < n; k++) begin
            #1;
            check("rr_grant", {30'd0, req_ready}, exp_grant ? 32'd2 : 32'd1);
            g = exp_grant;
            if (g) sb.push_back('{data: shf(req1_din, req1_shamt, req1_l_or_r, req1_a_or_l), id: 1'b1});
            else   sb.push_back('{data: shf(req0_din, req0_shamt, req0_l_or_r, req0_a_or_l), id: 1'b0});
            @(posedge clk); #1;
            check("exec_req_ready", {30'd0, req_ready}, 32'd0);
            if (g) begin
                req1_din = 8'($urandom); req1_shamt = 3'($urandom);
                req1_l_or_r = 1'($urandom); req1_a_or_l = 1'($urandom);
            end else begin
                req0_din = 8'($urandom); req0_shamt = 3'($urandom);
                req0_l_or_r = 1'($urandom); req0_a_or_l = 1'($urandom);
            end
            @(posedge clk); #1;
            check("rr_valid", {31'd0, res_valid}, 32'd1);
            check("done_req_ready", {30'd0, req_ready}, 32'd0);
            if (sb.size() == 0) begin
                check("sb_empty", 32'd0, 32'd1);
                e = '0;
            end else begin
                e = sb.pop_front();
            end
            check("rr_data", {24'd0, res_data}, {24'd0, e.data});
            check("rr_id", {31'd0, res_id}, {31'd0, e.id});
            @(posedge clk);
            exp_ops++;
            #1;
            check("rr_ops", {24'd0, ops_done}, exp_ops);
            exp_grant = ~g;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        exp_ops   = 0;
        exp_grant = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        req_valid = 2'b00; res_ready = 1'b0;
        req0_din = '0; req0_shamt = '0; req0_l_or_r = 1'b0; req0_a_or_l = 1'b0;
        req1_din = '0; req1_shamt = '0; req1_l_or_r = 1'b0; req1_a_or_l = 1'b0;
        do_reset();

        check("rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("rst_res_data", {24'd0, res_data}, 32'd0);
        check("rst_res_id", {31'd0, res_id}, 32'd0);
        check("rst_ops", {24'd0, ops_done}, 32'd0);
        check("rst_sh_din", {24'd0, sh_din}, 32'd0);
        check("rst_sh_ctl", {27'd0, sh_shamt, sh_l_or_r, sh_a_or_l}, 32'd0);
        check("rst_req_ready", {30'd0, req_ready}, 32'd0);

        // Single request, logical right
        issue(1'b0, 8'hAA, 3'd3, 1'b0, 1'b0, 8'h15);
        collect(0);
        // Arithmetic right and left forwarding on channel 1
        issue(1'b1, 8'hAA, 3'd3, 1'b0, 1'b1, 8'hF5);
        collect(0);
        issue(1'b1, 8'hAA, 3'd2, 1'b1, 1'b1, 8'hA8);
        check("sh_fwd_ctl", {27'd0, sh_shamt, sh_l_or_r, sh_a_or_l}, {27'd0, 3'd2, 1'b1, 1'b1});
        collect(0);

        // Simultaneous requests after reset, then sustained contention
        do_reset();
        req0_din = 8'h01; req0_shamt = 3'd1; req0_l_or_r = 1'b1; req0_a_or_l = 1'b0;
        req1_din = 8'h80; req1_shamt = 3'd7; req1_l_or_r = 1'b0; req1_a_or_l = 1'b0;
        check("pre_tie_expect0", {24'd0, shf(req0_din, req0_shamt, req0_l_or_r, req0_a_or_l)}, 32'h02);
        req_valid = 2'b11;
        contend(6);
        check("contend_ops6", {24'd0, ops_done}, 32'd6);
        req_valid = 2'b00;
        #1;

        // Backpressure in DONE with both channels requesting
        issue(1'b1, 8'h3C, 3'd1, 1'b0, 1'b1, 8'h1E);
        req_valid = 2'b11;
        collect(5);
        req_valid = 2'b00;
        exp_grant = 1'b0;

        // Reset while a result is waiting, with res_ready also asserted
        issue(1'b0, 8'h0F, 3'd4, 1'b1, 1'b0, 8'hF0);
        res_ready = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_valid", {31'd0, res_valid}, 32'd1);
        rst = 1'b1; res_ready = 1'b1; req_valid = 2'b11;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        exp_ops = 0;
        exp_grant = 1'b0;
        check("midrst_valid", {31'd0, res_valid}, 32'd0);
        check("midrst_ops", {24'd0, ops_done}, 32'd0);
        check("midrst_data", {24'd0, res_data}, 32'd0);
        contend(2);
        req_valid = 2'b00;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
